// File: rtl/clk_div_ctrl_if.sv
//------------------------------------------------------------------------------
// Module  : clk_div_ctrl_if
// Brief   : Enable, config handshake and divided-output bundle for clk_div_ctrl.
//           CLKDIV_CTRL_TICKCNT_EN adds the tick_cnt signal.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface clk_div_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             enable;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;
    logic [CNT_W-1:0] cur_div;
    logic             busy;
    logic             tick;
    logic             div_out;
`ifdef CLKDIV_CTRL_TICKCNT_EN
    logic [15:0]      tick_cnt;

    modport master (
        output enable, cfg_valid, cfg_div,
        input  cfg_ready, cfg_err, cur_div, busy, tick, div_out, tick_cnt
    );
    modport slave (
        input  enable, cfg_valid, cfg_div,
        output cfg_ready, cfg_err, cur_div, busy, tick, div_out, tick_cnt
    );
`else
    modport master (
        output enable, cfg_valid, cfg_div,
        input  cfg_ready, cfg_err, cur_div, busy, tick, div_out
    );
    modport slave (
        input  enable, cfg_valid, cfg_div,
        output cfg_ready, cfg_err, cur_div, busy, tick, div_out
    );
`endif
endinterface

`default_nettype wire

// File: rtl/clk_div_ctrl.sv
//------------------------------------------------------------------------------
// Module  : clk_div_ctrl
// Brief   : Run-time programmable clock-enable divider; new ratios take effect
//           only at a period boundary. CLKDIV_CTRL_TICKCNT_EN adds tick_cnt.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module clk_div_ctrl #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  wire logic     clk,
    input  wire logic     rst,
    clk_div_ctrl_if.slave bus
);

    localparam logic [1:0]       c_ST_IDLE     = 2'd0;
    localparam logic [1:0]       c_ST_RUN      = 2'd1;
    localparam logic [1:0]       c_ST_PEND     = 2'd2;
    localparam logic [CNT_W-1:0] c_DEFAULT_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] c_ONE         = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_MIN_DIV     = CNT_W'(2);

    typedef enum logic [1:0] {
        IDLE = c_ST_IDLE,
        RUN  = c_ST_RUN,
        PEND = c_ST_PEND
    } state_t;

    state_t           r_state,    w_state_nxt;
    logic [CNT_W-1:0] r_count,    w_count_nxt;
    logic [CNT_W-1:0] r_cur_div,  w_cur_div_nxt;
    logic [CNT_W-1:0] r_pend_div, w_pend_div_nxt;
    logic             r_div_out,  w_div_out_nxt;
    logic             r_cfg_err,  w_cfg_err_nxt;
    logic             w_cfg_ready;
    logic             w_xfer;
    logic             w_legal;
    logic             w_tick;
    logic [CNT_W:0]   w_high_len;

    assign w_cfg_ready = (r_state != PEND);
    assign w_xfer      = bus.cfg_valid & w_cfg_ready;
    assign w_legal     = w_xfer & (bus.cfg_div >= c_MIN_DIV);
    assign w_tick      = (r_state != IDLE) && (r_count == (r_cur_div - c_ONE));

    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_cur_div_nxt  = r_cur_div;
        w_pend_div_nxt = r_pend_div;
        w_cfg_err_nxt  = w_xfer & ~w_legal;
        case (r_state)
            IDLE: begin
                w_count_nxt = '0;
                if (w_legal) w_cur_div_nxt = bus.cfg_div;
                if (bus.enable) w_state_nxt = RUN;
            end
            RUN: begin
                if (!bus.enable) begin
                    w_state_nxt = IDLE;
                    w_count_nxt = '0;
                    if (w_legal) w_cur_div_nxt = bus.cfg_div;
                end else if (w_tick) begin
                    // A ratio arriving on the boundary cycle applies right away.
                    w_count_nxt = '0;
                    if (w_legal) w_cur_div_nxt = bus.cfg_div;
                end else begin
                    w_count_nxt = r_count + c_ONE;
                    if (w_legal) begin
                        w_pend_div_nxt = bus.cfg_div;
                        w_state_nxt    = PEND;
                    end
                end
            end
            PEND: begin
                if (!bus.enable) begin
                    w_state_nxt   = IDLE;
                    w_count_nxt   = '0;
                    w_cur_div_nxt = r_pend_div;
                end else if (w_tick) begin
                    w_state_nxt   = RUN;
                    w_count_nxt   = '0;
                    w_cur_div_nxt = r_pend_div;
                end else begin
                    w_count_nxt = r_count + c_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    // High for the first ceil(N/2) counts of the period that will be in force.
    assign w_high_len    = ({1'b0, w_cur_div_nxt} + {{CNT_W{1'b0}}, 1'b1}) >> 1;
    assign w_div_out_nxt = (w_state_nxt != IDLE) && ({1'b0, w_count_nxt} < w_high_len);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_cur_div  <= c_DEFAULT_DIV;
            r_pend_div <= c_DEFAULT_DIV;
            r_div_out  <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_cur_div  <= w_cur_div_nxt;
            r_pend_div <= w_pend_div_nxt;
            r_div_out  <= w_div_out_nxt;
            r_cfg_err  <= w_cfg_err_nxt;
        end
    end

    assign bus.cfg_ready = w_cfg_ready;
    assign bus.cfg_err   = r_cfg_err;
    assign bus.cur_div   = r_cur_div;
    assign bus.busy      = (r_state == PEND);
    assign bus.tick      = w_tick;
    assign bus.div_out   = r_div_out;

`ifdef CLKDIV_CTRL_TICKCNT_EN
    logic [15:0] r_tick_cnt;

    // A ratio change restarts the count even if it lands on a tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= 16'd0;
        end else if (w_cur_div_nxt != r_cur_div) begin
            r_tick_cnt <= 16'd0;
        end else if (w_tick) begin
            r_tick_cnt <= r_tick_cnt + 16'd1;
        end
    end

    assign bus.tick_cnt = r_tick_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_clk_div_ctrl
// Brief   : Randomized self-checking bench for clk_div_ctrl against a
//           period-level reference model. Honours CLKDIV_CTRL_TICKCNT_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_clk_div_ctrl;

    localparam int CNT_W       = 8;
    localparam int DEFAULT_DIV = 2;
    localparam int N_CYCLES    = 4000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    clk_div_ctrl_if #(.CNT_W(CNT_W)) bus ();

    clk_div_ctrl #(
        .CNT_W      (CNT_W),
        .DEFAULT_DIV(DEFAULT_DIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: position inside the current period plus divisor bookkeeping.
    int m_div;
    int m_pend;
    int m_pos;
    int m_tcnt;
    bit m_run;
    bit m_err;
    bit m_acc;
    int n_rst_done = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_div  = DEFAULT_DIV;
        m_pend = -1;
        m_pos  = 0;
        m_tcnt = 0;
        m_run  = 1'b0;
        m_err  = 1'b0;
        m_acc  = 1'b0;
    endtask

    task automatic check_outputs();
        check_eq("cfg_ready", 32'(bus.cfg_ready), 32'(m_pend < 0));
        check_eq("busy",      32'(bus.busy),      32'(m_pend >= 0));
        check_eq("cur_div",   32'(bus.cur_div),   32'(m_div));
        check_eq("tick",      32'(bus.tick),      32'(m_run && (m_pos == m_div - 1)));
        check_eq("div_out",   32'(bus.div_out),   32'(m_run && (m_pos < (m_div + 1) / 2)));
        check_eq("cfg_err",   32'(bus.cfg_err),   32'(m_err));
`ifdef CLKDIV_CTRL_TICKCNT_EN
        check_eq("tick_cnt",  32'(bus.tick_cnt),  32'(m_tcnt));
`endif
    endtask

    // Advance the model across the coming rising edge using the driven inputs.
    task automatic model_step();
        bit xfer;
        bit legal;
        bit tk;
        int old_div;
        int req;
        req     = int'(bus.cfg_div);
        xfer    = bus.cfg_valid && (m_pend < 0);
        legal   = xfer && (req >= 2);
        tk      = m_run && (m_pos == m_div - 1);
        old_div = m_div;
        m_err   = xfer && (req < 2);
        m_acc   = xfer;
        if (tk) m_tcnt = (m_tcnt + 1) % 65536;
        if (!bus.enable) begin
            if (m_pend >= 0) m_div = m_pend;
            if (legal) m_div = req;
            m_pend = -1;
            m_run  = 1'b0;
            m_pos  = 0;
        end else if (!m_run) begin
            if (legal) m_div = req;
            m_run = 1'b1;
            m_pos = 0;
        end else if (tk) begin
            m_pos = 0;
            if (m_pend >= 0) begin
                m_div  = m_pend;
                m_pend = -1;
            end else if (legal) begin
                m_div = req;
            end
        end else begin
            m_pos++;
            if (legal) m_pend = req;
        end
        if (m_div != old_div) m_tcnt = 0;
    endtask

    task automatic pick_inputs(input int cyc);
        int r;
        if (m_acc) bus.cfg_valid = 1'b0;
        if (bus.enable) begin
            if ($urandom_range(0, 39) == 0) bus.enable = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
            bus.enable = 1'b1;
        end
        if (cyc >= 10 && !bus.cfg_valid && $urandom_range(0, 4) == 0) begin
            r = int'($urandom_range(0, 99));
            bus.cfg_valid = 1'b1;
            if (r < 12)      bus.cfg_div = CNT_W'($urandom_range(0, 1));
            else if (r < 15) bus.cfg_div = CNT_W'(255);
            else             bus.cfg_div = CNT_W'($urandom_range(2, 12));
        end
    endtask

    initial begin
        bus.enable    = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_div   = '0;
        model_reset();
        @(negedge clk);
        check_outputs();
        @(negedge clk);
        check_outputs();
        rst        = 1'b0;
        bus.enable = 1'b1;
        model_step();
        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(negedge clk);
            check_outputs();
            // Asynchronous reset landing between edges while a change is pending.
            if (m_pend >= 0 && n_rst_done < 3 && $urandom_range(0, 9) == 0) begin
                #1 rst = 1'b1;
                #1;
                model_reset();
                check_outputs();
                n_rst_done++;
                bus.cfg_valid = 1'b0;
                @(negedge clk);
                check_outputs();
                rst = 1'b0;
            end
            pick_inputs(cyc);
            model_step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
